// File: rtl/ram_responder_pkg.sv
// Shared definitions for the RAM responder and the initiator-side blocks that talk to it.
//   state_t     : responder FSM states (CLEAR sweep, IDLE, RESP holding a read result)
//   DEF_ADDR_W  : default address width (depth = 2**DEF_ADDR_W words)
//   DEF_DATA_W  : default data word width
package ram_responder_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage : ram_responder_pkg

// File: rtl/ram_array.sv
// Single-port synchronous RAM with a registered read port (read-before-write), block-RAM inferable.
// No reset: contents are defined only by whoever writes them.
//   address : word address
//   clock   : rising-edge clock
//   data    : write data
//   wren    : write enable
//   q       : registered read data of mem[address] from the previous edge
module ram_array #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic [ADDR_W-1:0] address,
    input  logic              clock,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port plus registered read of the same address.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule : ram_array

// File: rtl/ram_responder.sv
// Valid/ready RAM responder: clears the whole array after reset, then serves single-word
// writes (no response) and reads (one response, at most one outstanding).
//   clock, reset_n           : clock and asynchronous active-low reset
//   req_valid / req_ready    : request handshake
//   req_wen                  : 1 = write, 0 = read
//   req_address / req_data   : request word address and write data
//   rsp_valid / rsp_ready    : read-response handshake
//   rsp_data                 : read result, 0 when no response is held
//   busy                     : high while the post-reset clear sweep runs
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
);

    // One extra bit so the counter's MSB flags that the last address was written.
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state;
    logic [CNT_W-1:0]  clr_cnt;
    logic [CNT_W-1:0]  clr_next;
    logic [ADDR_W-1:0] rd_addr;
    logic              accept;
    logic              rd_accept;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    // Handshake: in RESP a new request is only taken when the current result retires.
    always_comb begin
        req_ready = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            RESP:    req_ready = rsp_ready;
            default: req_ready = 1'b0;
        endcase
    end

    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_wen;
    assign clr_next  = clr_cnt + CNT_W'(1);

    // RAM port mux: clear sweep, stalled response (re-read held address so q stays put),
    // or the live request path.
    always_comb begin
        ram_addr  = req_address;
        ram_wdata = req_data;
        ram_wren  = 1'b0;
        case (state)
            CLEAR: begin
                ram_addr  = clr_cnt[ADDR_W-1:0];
                ram_wdata = '0;
                ram_wren  = 1'b1;
            end
            RESP: begin
                if (!rsp_ready) begin
                    ram_addr = rd_addr;
                end else begin
                    ram_wren = accept && req_wen;
                end
            end
            default: begin
                ram_wren = accept && req_wen;
            end
        endcase
    end

    // FSM, clear counter and registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b1;
            rd_addr   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_next;
                    if (clr_next[ADDR_W]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (rd_accept) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rd_addr   <= req_address;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        if (rd_accept) begin
                            rd_addr <= req_address;
                        end else begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= CLEAR;
                    clr_cnt   <= '0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

    // The RAM's registered q is the read result; masked so nothing leaks out when idle.
    assign rsp_data = rsp_valid ? ram_q : '0;

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .address (ram_addr),
        .clock   (clock),
        .data    (ram_wdata),
        .wren    (ram_wren),
        .q       (ram_q)
    );

endmodule : ram_responder

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: directed scenarios plus a random request stream,
// all compared against a transaction-level memory model.
module tb_ram_responder;

    logic       clock;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_wen;
    logic [7:0] req_address;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;

    ram_responder #(
        .ADDR_W (8),
        .DATA_W (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wen     (req_wen),
        .req_address (req_address),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: memory image, pending response and remaining clear cycles.
    logic [7:0] mem_m [256];
    logic       m_valid;
    logic [7:0] m_data;
    int         clear_left;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive the request, check ready, advance model at the edge, check outputs.
    task automatic cycle(input logic v, input logic w, input logic [7:0] a,
                         input logic [7:0] d, input logic rr);
        logic exp_ready;
        logic acc;
        req_valid   = v;
        req_wen     = w;
        req_address = a;
        req_data    = d;
        rsp_ready   = rr;
        #1;
        exp_ready = (clear_left == 0) && (!m_valid || rr);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        acc = v && exp_ready;
        @(posedge clock);
        if (clear_left > 0) begin
            clear_left--;
        end else if (acc && !w) begin
            m_valid = 1'b1;
            m_data  = mem_m[a];
        end else begin
            if (acc && w) mem_m[a] = d;
            if (m_valid && rr) m_valid = 1'b0;
        end
        #1;
        check("busy", 32'(busy), 32'(clear_left > 0));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) check("rsp_data", 32'(rsp_data), 32'(m_data));
    endtask

    // Asynchronous reset pulse starting away from the edge; model restarts its clear sweep.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        @(posedge clock);
        #1;
        reset_n    = 1'b1;
        m_valid    = 1'b0;
        m_data     = '0;
        clear_left = 256;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
                  8'($urandom), 1'b1);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_wen     = 1'b0;
        req_address = '0;
        req_data    = '0;
        rsp_ready   = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        clear_left  = 256;
        @(posedge clock);
        #1;

        // Full clear sweep with requests attempted throughout (must be ignored).
        pulse_reset();
        idle_cycles(256);
        cycle(1'b1, 1'b0, 8'h26, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // Read-after-write.
        cycle(1'b1, 1'b1, 8'h26, 8'h33, 1'b1);
        cycle(1'b1, 1'b0, 8'h26, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // Backpressured read: 5 stall cycles with a competing request offered.
        cycle(1'b1, 1'b0, 8'h26, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'h26, 8'hEE, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // Back-to-back reads with no gap.
        cycle(1'b1, 1'b1, 8'h00, 8'h10, 1'b1);
        cycle(1'b1, 1'b1, 8'h01, 8'h11, 1'b1);
        cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h01, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // Alternating write/read stream on one address.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 8'h26, 8'(8'h33 + i), 1'b1);
            cycle(1'b1, 1'b0, 8'h26, 8'h00, 1'b1);
        end
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        // Random traffic, addresses biased to a small window for collisions.
        for (int i = 0; i < 2000; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom),
                  8'($urandom), 1'($urandom_range(0, 3) != 0));
        end

        // Reset while a response is held, then again partway through the clear sweep.
        cycle(1'b1, 1'b1, 8'h26, 8'h5A, 1'b1);
        cycle(1'b1, 1'b0, 8'h26, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        pulse_reset();
        idle_cycles(100);
        pulse_reset();
        idle_cycles(256);
        cycle(1'b1, 1'b0, 8'h26, 8'h00, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram_responder

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the address width; depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, giving the data word width.
REQ-003 SHALL have port clock, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 SHALL have port req_wen, input, 1 bit: 1 = write request, 0 = read request.
REQ-008 SHALL have port req_address, input, ADDR_W bits: word address of the request.
REQ-009 SHALL have port req_data, input, DATA_W bits: write data; ignored on reads.
REQ-010 SHALL have port rsp_valid, output, 1 bit: rsp_data holds a read result.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the initiator accepts the read result.
REQ-012 SHALL have port rsp_data, output, DATA_W bits: read result.
REQ-013 SHALL have port busy, output, 1 bit: high while the CLEAR sweep runs.

Function
REQ-014 SHALL implement the FSM states CLEAR, IDLE and RESP.
REQ-015 CLEAR: SHALL write 0 to one address per cycle, ascending from 0, with req_ready=0 and busy=1; after address 2**ADDR_W-1 is written, SHALL go to IDLE (2**ADDR_W cycles total, no early exit).
REQ-016 SHALL accept a request on any cycle where req_valid=1 and req_ready=1 at the clock edge.
REQ-017 IDLE: SHALL drive req_ready=1; an accepted write SHALL store req_data at req_address on that edge, and the FSM SHALL stay in IDLE with no response.
REQ-018 IDLE: an accepted read SHALL load rsp_data with mem[req_address] and move to RESP, so rsp_valid=1 exactly one cycle after acceptance.
REQ-019 RESP: SHALL hold rsp_valid=1 and rsp_data stable until a cycle with rsp_ready=1.
REQ-020 RESP: SHALL drive req_ready equal to rsp_ready, so one read can complete while the next request is accepted in the same cycle.
REQ-021 RESP, rsp_ready=1 with a new read accepted: SHALL stay in RESP and load the new read data; rsp_valid SHALL have no gap cycle.
REQ-022 RESP, rsp_ready=1 with a write or no request accepted: SHALL perform any accepted write and return to IDLE, with rsp_valid=0 in the next cycle.
REQ-023 Read-after-write: a read accepted the cycle after a write to the same address SHALL return the new data.
REQ-024 Address handling: SHALL use req_address modulo 2**ADDR_W with no out-of-range error; the CLEAR counter SHALL be ADDR_W+1 bits wide to detect completion.
REQ-025 SHALL have at most one read response outstanding; a write never produces a response.

Reset
REQ-026 While reset_n=0, SHALL force state=CLEAR, clear counter=0, rsp_valid=0, rsp_data=0, req_ready=0 and busy=1, all asynchronously.
REQ-027 Reset asserted in any state, including mid-CLEAR or during RESP, SHALL drop any pending response and restart the full CLEAR sweep from address 0 after reset_n rises.
REQ-028 Memory contents SHALL be defined only by the CLEAR sweep; the array itself has no reset port.

Structure
REQ-029 A shared package SHALL hold the state enum (CLEAR, IDLE, RESP) and the default ADDR_W/DATA_W constants, reused by initiator-side blocks.
REQ-030 The storage array SHALL be one sub-module, ram_array: single-port synchronous RAM with inputs address, clock, data and wren, and registered output q, inferable as block RAM.
REQ-031 The FSM, handshake logic and clear counter SHALL live in ram_responder; the address/data/wren mux between CLEAR and the request path SHALL feed ram_array.

Verification
REQ-032 Reset release -> busy=1 and req_ready=0 for exactly 256 cycles, then busy=0 and req_ready=1; a read of address 0x26 then returns 0x00.
REQ-033 Write 0x33 to 0x26, then read 0x26 on the next cycle with rsp_ready=1 -> rsp_valid=1 one cycle after the read is accepted, rsp_data=0x33.
REQ-034 Read with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stay stable and req_ready=0 throughout; when rsp_ready rises, the response completes and req_ready=1 in that same cycle.
REQ-035 Back-to-back reads of 0x00, 0x01 and 0xFF (holding 0x10, 0x11, 0xFF) with rsp_ready=1 -> rsp_valid high 3 consecutive cycles returning 0x10, 0x11, 0xFF in order.
REQ-036 Alternating write/read stream on 0x26, each write value +1 from 0x33 -> every read returns the most recent write.
REQ-037 reset_n pulsed low during RESP and again mid-CLEAR at count 100 -> rsp_valid drops immediately; a full 256-cycle sweep follows; address 0x26 reads 0x00 afterwards.
